// File: rtl/video_proc_ctrl_if.sv
// video_proc_ctrl_if: configuration write handshake between a host and the video controller
interface video_proc_ctrl_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_thresh;

    modport master (output cfg_valid, output cfg_mode, output cfg_thresh, input cfg_ready);
    modport slave (input cfg_valid, input cfg_mode, input cfg_thresh, output cfg_ready);
endinterface

// File: rtl/video_proc_ctrl.sv
// video_proc_ctrl: frame-synchronous config shadowing plus frame and pixel statistics
module video_proc_ctrl (
    input  logic                     clk,
    input  logic                     rst_n,
    video_proc_ctrl_if.slave         cfg,
    input  logic                     pre_image_vsync,
    input  logic                     pre_image_clken,
    input  logic                     pre_data_valid,
    output logic [1:0]               mode,
    output logic [7:0]               threshold,
    output logic                     cfg_applied,
    output logic [15:0]              frame_cnt,
    output logic [23:0]              pix_cnt_last,
    output logic                     pending
);
    typedef enum logic {IDLE, PENDING} state_t;

    state_t      state;
    logic        vs_d;
    logic [1:0]  sh_mode;
    logic [7:0]  sh_thresh;
    logic [23:0] pix_cnt;
    logic        vs_rise;
    logic        pix_qual;

    assign vs_rise       = pre_image_vsync & ~vs_d;
    assign pix_qual      = pre_image_clken & pre_data_valid;
    assign cfg.cfg_ready = (state == IDLE);

    // Config FSM: capture a write into the shadow, commit it on the next frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pending     <= 1'b0;
            cfg_applied <= 1'b0;
            mode        <= 2'b00;
            threshold   <= 8'd128;
            sh_mode     <= 2'b00;
            sh_thresh   <= 8'd128;
        end else begin
            cfg_applied <= 1'b0;
            if (state == IDLE) begin
                if (cfg.cfg_valid) begin
                    state     <= PENDING;
                    pending   <= 1'b1;
                    sh_mode   <= (cfg.cfg_mode == 2'b11) ? 2'b00 : cfg.cfg_mode;
                    sh_thresh <= cfg.cfg_thresh;
                end
            end else if (vs_rise) begin
                state       <= IDLE;
                pending     <= 1'b0;
                mode        <= sh_mode;
                threshold   <= sh_thresh;
                cfg_applied <= 1'b1;
            end
        end
    end

    // Frame and pixel statistics; a pixel coinciding with the frame start opens the new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d         <= 1'b0;
            frame_cnt    <= 16'd0;
            pix_cnt      <= 24'd0;
            pix_cnt_last <= 24'd0;
        end else begin
            vs_d <= pre_image_vsync;
            if (vs_rise) begin
                frame_cnt    <= frame_cnt + 16'd1;
                pix_cnt_last <= pix_cnt;
                pix_cnt      <= {23'd0, pix_qual};
            end else if (pix_qual && pix_cnt != 24'hFFFFFF) begin
                pix_cnt <= pix_cnt + 24'd1;
            end
        end
    end
endmodule

// File: tb/tb_video_proc_ctrl.sv
// tb_video_proc_ctrl: directed stimulus with a scoreboard of expected config applies
module tb_video_proc_ctrl;
    typedef struct packed {
        logic [1:0] m;
        logic [7:0] t;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        pre_image_vsync;
    logic        pre_image_clken;
    logic        pre_data_valid;
    logic [1:0]  mode;
    logic [7:0]  threshold;
    logic        cfg_applied;
    logic [15:0] frame_cnt;
    logic [23:0] pix_cnt_last;
    logic        pending;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_frames = 16'd0;

    video_proc_ctrl_if cfg ();

    video_proc_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg             (cfg),
        .pre_image_vsync (pre_image_vsync),
        .pre_image_clken (pre_image_clken),
        .pre_data_valid  (pre_data_valid),
        .mode            (mode),
        .threshold       (threshold),
        .cfg_applied     (cfg_applied),
        .frame_cnt       (frame_cnt),
        .pix_cnt_last    (pix_cnt_last),
        .pending         (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every apply pulse must match the oldest outstanding expected config
    always @(negedge clk) begin
        if (rst_n && cfg_applied) begin
            if (sb.size() == 0) begin
                chk("unexpected_apply", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("apply_mode", {30'd0, mode}, {30'd0, e.m});
                chk("apply_thresh", {24'd0, threshold}, {24'd0, e.t});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cfg_write(input logic [1:0] m, input logic [7:0] t);
        cfg.cfg_valid  = 1'b1;
        cfg.cfg_mode   = m;
        cfg.cfg_thresh = t;
        tick();
        cfg.cfg_valid  = 1'b0;
    endtask

    task automatic vsync_pulse();
        pre_image_vsync = 1'b1;
        tick();
        pre_image_vsync = 1'b0;
        tick();
        exp_frames++;
    endtask

    task automatic feed(input int n);
        for (int k = 0; k < n; k++) begin
            if (k % 4 == 3) begin
                pre_image_clken = 1'b0;
                pre_data_valid  = 1'b1;
                tick();
            end
            if (k % 7 == 5) begin
                pre_image_clken = 1'b1;
                pre_data_valid  = 1'b0;
                tick();
            end
            pre_image_clken = 1'b1;
            pre_data_valid  = 1'b1;
            tick();
        end
        pre_image_clken = 1'b0;
        pre_data_valid  = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        pre_image_vsync = 1'b0;
        pre_image_clken = 1'b0;
        pre_data_valid  = 1'b0;
        cfg.cfg_valid   = 1'b0;
        cfg.cfg_mode    = 2'b00;
        cfg.cfg_thresh  = 8'd0;
        repeat (2) tick();
        chk("rst_mode", {30'd0, mode}, 32'd0);
        chk("rst_thresh", {24'd0, threshold}, 32'd128);
        chk("rst_pending", {31'd0, pending}, 32'd0);
        chk("rst_ready", {31'd0, cfg.cfg_ready}, 32'd1);
        chk("rst_frame", {16'd0, frame_cnt}, 32'd0);
        chk("rst_pixlast", {8'd0, pix_cnt_last}, 32'd0);
        chk("rst_applied", {31'd0, cfg_applied}, 32'd0);
        rst_n = 1'b1;
        tick();

        // basic apply
        cfg_write(2'b10, 8'd100);
        sb.push_back('{m: 2'b10, t: 8'd100});
        chk("basic_pending", {31'd0, pending}, 32'd1);
        chk("basic_ready", {31'd0, cfg.cfg_ready}, 32'd0);
        repeat (3) tick();
        chk("basic_hold_mode", {30'd0, mode}, 32'd0);
        chk("basic_hold_thresh", {24'd0, threshold}, 32'd128);
        vsync_pulse();
        chk("basic_pulse_width", {31'd0, cfg_applied}, 32'd0);
        chk("basic_cleared", {31'd0, pending}, 32'd0);
        chk("basic_frame", {16'd0, frame_cnt}, {16'd0, exp_frames});

        // blocked second write
        cfg_write(2'b01, 8'd50);
        sb.push_back('{m: 2'b01, t: 8'd50});
        cfg.cfg_valid  = 1'b1;
        cfg.cfg_mode   = 2'b10;
        cfg.cfg_thresh = 8'd200;
        chk("blocked_ready", {31'd0, cfg.cfg_ready}, 32'd0);
        tick();
        cfg.cfg_valid = 1'b0;
        chk("blocked_pending", {31'd0, pending}, 32'd1);
        vsync_pulse();
        chk("blocked_mode", {30'd0, mode}, 32'd1);
        chk("blocked_thresh", {24'd0, threshold}, 32'd50);

        // write on the same clock as the frame start
        cfg.cfg_valid   = 1'b1;
        cfg.cfg_mode    = 2'b10;
        cfg.cfg_thresh  = 8'd77;
        pre_image_vsync = 1'b1;
        tick();
        cfg.cfg_valid   = 1'b0;
        pre_image_vsync = 1'b0;
        exp_frames++;
        sb.push_back('{m: 2'b10, t: 8'd77});
        chk("simul_no_apply", {31'd0, cfg_applied}, 32'd0);
        chk("simul_pending", {31'd0, pending}, 32'd1);
        chk("simul_mode_kept", {30'd0, mode}, 32'd1);
        tick();
        vsync_pulse();
        chk("simul_mode", {30'd0, mode}, 32'd2);

        // reserved mode stored as bypass
        cfg_write(2'b11, 8'd9);
        sb.push_back('{m: 2'b00, t: 8'd9});
        vsync_pulse();
        chk("resv_mode", {30'd0, mode}, 32'd0);
        chk("resv_thresh", {24'd0, threshold}, 32'd9);

        // pixel counting with gaps
        feed(3072);
        vsync_pulse();
        chk("pix_small", {8'd0, pix_cnt_last}, 32'd3072);
        chk("pix_frame", {16'd0, frame_cnt}, {16'd0, exp_frames});
        force dut.pix_cnt = 24'd306560;
        #1 release dut.pix_cnt;
        feed(640);
        vsync_pulse();
        chk("pix_vga", {8'd0, pix_cnt_last}, 32'd307200);

        // pixel on the frame start opens the new frame
        pre_image_vsync = 1'b1;
        pre_image_clken = 1'b1;
        pre_data_valid  = 1'b1;
        tick();
        exp_frames++;
        pre_image_vsync = 1'b0;
        chk("pix_empty_frame", {8'd0, pix_cnt_last}, 32'd0);
        repeat (4) tick();
        pre_image_clken = 1'b0;
        pre_data_valid  = 1'b0;
        vsync_pulse();
        chk("pix_reload", {8'd0, pix_cnt_last}, 32'd5);

        // saturation
        force dut.pix_cnt = 24'hFFFFFD;
        #1 release dut.pix_cnt;
        feed(5);
        vsync_pulse();
        chk("pix_sat", {8'd0, pix_cnt_last}, 32'hFFFFFF);

        // frame counter wrap
        force dut.frame_cnt = 16'hFFFF;
        #1 release dut.frame_cnt;
        exp_frames = 16'hFFFF;
        vsync_pulse();
        chk("frame_wrap", {16'd0, frame_cnt}, {16'd0, exp_frames});

        // reset while pending discards the write
        cfg_write(2'b01, 8'd33);
        chk("rstp_pending", {31'd0, pending}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstp_mode", {30'd0, mode}, 32'd0);
        chk("rstp_thresh", {24'd0, threshold}, 32'd128);
        chk("rstp_pend", {31'd0, pending}, 32'd0);
        chk("rstp_frame", {16'd0, frame_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        pre_image_vsync = 1'b1;
        tick();
        chk("rstp_no_apply", {31'd0, cfg_applied}, 32'd0);
        pre_image_vsync = 1'b0;
        tick();
        chk("rstp_thresh_kept", {24'd0, threshold}, 32'd128);

        // vsync already high when reset releases counts as a frame start
        rst_n           = 1'b0;
        pre_image_vsync = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_vs_frame", {16'd0, frame_cnt}, 32'd1);
        pre_image_vsync = 1'b0;
        tick();

        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/video_proc_ctrl.md
VIDEO_PROC_CTRL -- requirements
Module: video_proc_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock for all logic, the cmos pixel clock.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port cfg_valid, input, 1 bit: configuration write request.
REQ-004 SHALL have port cfg_ready, output, 1 bit: configuration write can be accepted.
REQ-005 SHALL have port cfg_mode, input, 2 bits: 00 bypass, 01 gray, 10 binary, 11 reserved.
REQ-006 SHALL have port cfg_thresh, input, 8 bits: binarization threshold.
REQ-007 SHALL have port pre_image_vsync, input, 1 bit: frame sync of the incoming stream.
REQ-008 SHALL have port pre_image_clken, input, 1 bit: pixel clock enable.
REQ-009 SHALL have port pre_data_valid, input, 1 bit: pixel data valid.
REQ-010 SHALL have port mode, output, 2 bits: active path select driven to the processing datapath.
REQ-011 SHALL have port threshold, output, 8 bits: active threshold driven to the binarization stage.
REQ-012 SHALL have port cfg_applied, output, 1 bit: one-cycle pulse when the shadow configuration becomes active.
REQ-013 SHALL have port frame_cnt, output, 16 bits: count of frame starts.
REQ-014 SHALL have port pix_cnt_last, output, 24 bits: pixel count of the last completed frame.
REQ-015 SHALL have port pending, output, 1 bit: a shadow configuration is waiting for a frame boundary.

Function
REQ-016 SHALL detect the frame boundary as vs_rise = pre_image_vsync & ~vs_d, where vs_d is pre_image_vsync registered once.
REQ-017 SHALL implement a two-state FSM:
- IDLE: cfg_ready=1, pending=0.
- PENDING: cfg_ready=0, pending=1.
REQ-018 SHALL transition IDLE->PENDING on a clock where cfg_valid=1, loading the shadow registers with cfg_mode and cfg_thresh.
REQ-019 SHALL store reserved cfg_mode 11 in the shadow as 00 (bypass).
REQ-020 SHALL ignore cfg_valid while in PENDING; there is no overwrite of a pending configuration.
REQ-021 SHALL, in PENDING on a clock with vs_rise=1:
- load mode and threshold from the shadow at that edge;
- return to IDLE;
- assert cfg_applied for exactly the following cycle (registered pulse).
REQ-022 SHALL, on simultaneous cfg_valid and vs_rise in IDLE, accept the write and apply it at the next vs_rise, never the current one.
REQ-023 SHALL change mode and threshold only at a vs_rise edge while in PENDING; they SHALL remain stable through the frame.
REQ-024 SHALL increment frame_cnt by 1 on every vs_rise, wrapping 16'hFFFF->16'h0000.
REQ-025 SHALL count one pixel on each clock where pre_image_clken=1 and pre_data_valid=1, in an internal 24-bit counter saturating at 24'hFFFFFF.
REQ-026 SHALL, on vs_rise:
- load pix_cnt_last with the internal counter value;
- reload the counter with 1 if a pixel qualifies in that same cycle, else 0.
REQ-027 SHALL register all outputs; there is no combinational path from inputs to outputs except cfg_ready, which is decoded from the state.

Reset
REQ-028 SHALL, on rst_n=0 and asynchronously, force:
- state to IDLE;
- mode=00, threshold=8'd128;
- shadow registers to mode=00, threshold=8'd128;
- cfg_applied=0, frame_cnt=0, pix_cnt_last=0, internal pixel counter=0, vs_d=0, pending=0.
REQ-029 SHALL, on reset asserted mid-PENDING, discard the pending configuration with no cfg_applied pulse.
REQ-030 SHALL treat vsync high at reset release as a vs_rise on the first clock, because vs_d resets to 0.

Verification
REQ-031 SHALL cover basic apply:
- stimulus: write mode=10, thresh=8'd100, then one vsync rise;
- response: mode/threshold unchanged until the rise edge, then 10/100, cfg_applied high one cycle, pending cleared.
REQ-032 SHALL cover blocked second write:
- stimulus: write 01/50, then write 10/200 before any vsync;
- response: second write ignored (cfg_ready=0); 01/50 applied at the next rise.
REQ-033 SHALL cover simultaneous write and vsync:
- stimulus: cfg_valid in IDLE on the same clock as vs_rise;
- response: no apply on that rise; applied at the following rise.
REQ-034 SHALL cover pixel counting:
- stimulus: 640x480 qualifying pixels between two vsync rises, with clken gaps interleaved;
- response: pix_cnt_last=307200; frame_cnt increments by 1 per rise; wrap from 16'hFFFF to 0 checked by forcing the count near the limit.
REQ-035 SHALL cover reserved mode and reset:
- stimulus: write cfg_mode=11, then apply;
- response: mode=00.
- stimulus: assert rst_n low while PENDING;
- response: mode=00, threshold=128, pending=0, no cfg_applied pulse.
